pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//  Drives write-enable and flush for the PC and every pipeline register.
//  Resolves load-use hazards, taken-branch squashes, data-memory wait
//  handshakes and HALT draining. Keeps a saturating stall-cycle counter.
// PARAMETERS
//  CNT_W        16  width of stall_cnt
//  DRAIN_CYCLES 3   cycles spent draining EX/MEM/WB after HALT decode (>=1)
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      asynchronous, active-low reset
//  id_rs           in   5      rs field of instruction in ID
//  id_rt           in   5      rt field of instruction in ID
//  id_halt         in   1      instruction in ID is HALT
//  ex_memread      in   1      instruction in EX is a load
//  ex_rt           in   5      destination register of load in EX
//  ex_branch_taken in   1      branch in EX resolved taken
//  mem_req         in   1      MEM stage has an active data-memory access
//  mem_ready       in   1      data memory completes the access this cycle
//  pc_we           out  1      PC update enable
//  ifid_we         out  1      IF/ID register enable
//  ifid_flush      out  1      IF/ID load bubble (NOP)
//  idex_flush      out  1      ID/EX load bubble
//  exmem_we        out  1      EX/MEM register enable
//  memwb_we        out  1      MEM/WB register enable
//  halted          out  1      pipeline fully drained and stopped
//  stall_cnt       out  CNT_W  count of cycles with pc_we==0 in RUN/MEM_WAIT
// BEHAVIOUR
//  - One clock domain; rst_n asynchronous, active-low.
//  - While rst_n=0: state=RUN, drain counter=0, stall_cnt=0, halted=0.
//    All enables=0 and flushes=0.
//  - Enables/flushes are combinational from state + inputs (0-cycle latency).
//    State, drain counter and stall_cnt are registered.
//  - Default (no event): all we=1, flushes=0.
//  - The ID/EX register is written every cycle unless frozen. idex_flush
//    selects a bubble as the written value.
//  - FSM states: RUN, MEM_WAIT, DRAIN, HALTED.
//  - RUN evaluation order, highest priority first:
//    1 MEM freeze: mem_req & !mem_ready -> all we=0, flushes=0; next MEM_WAIT.
//    2 Branch: ex_branch_taken -> all we=1, ifid_flush=1, idex_flush=1.
//      Stay RUN. Any load-use or HALT in ID is ignored (it is squashed).
//    3 Load-use: ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt)
//      -> pc_we=0, ifid_we=0, idex_flush=1, exmem_we=memwb_we=1.
//      HALT in ID is not accepted this cycle.
//    4 Halt: id_halt -> pc_we=0, ifid_flush=1, idex_flush=0 (HALT enters EX).
//      Other we=1; load drain counter with DRAIN_CYCLES; next DRAIN.
//  - MEM_WAIT: while !mem_ready, full freeze as in item 1.
//    When mem_ready=1, apply RUN evaluation items 2-4 this cycle; next RUN,
//    or DRAIN if item 4 fires.
//  - DRAIN: pc_we=0, ifid_we=1, ifid_flush=1, idex_flush=1, exmem_we=1,
//    memwb_we=1.
//    A MEM freeze (mem_req & !mem_ready) sets all we=0 and holds the counter.
//    Otherwise the counter decrements; at 1->0, next HALTED.
//    ex_branch_taken and id_halt are ignored.
//  - HALTED: all we=0, flushes=0, halted=1. Exit only by reset.
//  - stall_cnt: +1 per cycle in RUN/MEM_WAIT with pc_we=0.
//    Saturates at 2^CNT_W-1. Frozen in DRAIN/HALTED.
//  - Reset mid-operation (any state): immediate return to RUN with cleared
//    counters. An in-flight memory wait is abandoned.
// TESTING
//  1 Load-use: ex_memread=1, ex_rt=8, id_rs=8 for one cycle.
//    Expect pc_we=0, ifid_we=0, idex_flush=1, stall_cnt 0->1.
//    With ex_rt=0, expect no stall.
//  2 Branch + load-use same cycle: ex_branch_taken=1, load-use match.
//    Expect pc_we=1, ifid_flush=1, idex_flush=1, stall_cnt unchanged.
//  3 Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then ready.
//    Expect all we=0 for 4 cycles, stall_cnt +4, enables=1 on the ready
//    cycle, state RUN.
//  4 Halt: id_halt=1 in RUN.
//    Expect DRAIN for 3 cycles with exmem_we=memwb_we=1, then halted=1
//    and all we=0 permanently. A later id_halt or branch has no effect.
//  5 Memory wait during DRAIN: mem_req=1, mem_ready=0 for 2 cycles in DRAIN.
//    Expect halted asserted 2 cycles later than test 4; stall_cnt unchanged.
//  6 Reset: drop rst_n in MEM_WAIT and in HALTED.
//    Expect immediate all we=0, halted=0. After release: RUN, stall_cnt=0.
//    Saturation: force CNT_W=4 with 20 stall cycles; expect stall_cnt=15.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Central hazard/stall sequencer for the 5-stage pipeline: drives PC and
// pipeline-register enables/flushes, drains on HALT, counts stall cycles.
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  S_RUN      | normal issue; branch/load-use/halt resolved by priority
//  S_MEM_WAIT | data memory busy, whole pipe frozen until mem_ready
//  S_DRAIN    | HALT accepted, flushing front end while EX/MEM/WB retire
//  S_HALTED   | drained and stopped, left only through reset
module pipeline_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_halt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_DRAIN, S_HALTED} state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic pc_we_c, ifid_we_c, ifid_flush_c, idex_flush_c, exmem_we_c, memwb_we_c;
    logic resolve, load_use, mem_freeze;

    assign load_use   = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign mem_freeze = mem_req && !mem_ready;

    always_comb begin
        pc_we_c      = 1'b1;
        ifid_we_c    = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        exmem_we_c   = 1'b1;
        memwb_we_c   = 1'b1;
        state_d      = state_q;
        drain_d      = drain_q;
        stall_d      = stall_q;
        resolve      = 1'b0;

        case (state_q)
            S_RUN: begin
                if (mem_freeze) begin
                    {pc_we_c, ifid_we_c, exmem_we_c, memwb_we_c} = 4'b0000;
                    state_d = S_MEM_WAIT;
                end else begin
                    resolve = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (!mem_ready) begin
                    {pc_we_c, ifid_we_c, exmem_we_c, memwb_we_c} = 4'b0000;
                end else begin
                    resolve = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                pc_we_c      = 1'b0;
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                if (mem_freeze) begin
                    // frozen pipe: nothing is loaded, so bubbles are suppressed too
                    {ifid_we_c, exmem_we_c, memwb_we_c} = 3'b000;
                    ifid_flush_c = 1'b0;
                    idex_flush_c = 1'b0;
                end else begin
                    drain_d = drain_q - DW'(1);
                    if (drain_q == DW'(1)) state_d = S_HALTED;
                end
            end
            default: begin
                {pc_we_c, ifid_we_c, exmem_we_c, memwb_we_c} = 4'b0000;
            end
        endcase

        if (resolve) begin
            if (ex_branch_taken) begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
            end else if (load_use) begin
                pc_we_c      = 1'b0;
                ifid_we_c    = 1'b0;
                idex_flush_c = 1'b1;
            end else if (id_halt) begin
                pc_we_c      = 1'b0;
                ifid_flush_c = 1'b1;
                drain_d      = DW'(DRAIN_CYCLES);
                state_d      = S_DRAIN;
            end
        end

        if ((state_q == S_RUN || state_q == S_MEM_WAIT) && !pc_we_c && (stall_q != '1))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            drain_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    // reset forces every control quiet, overriding the RUN defaults
    assign pc_we      = rst_n & pc_we_c;
    assign ifid_we    = rst_n & ifid_we_c;
    assign ifid_flush = rst_n & ifid_flush_c;
    assign idex_flush = rst_n & idex_flush_c;
    assign exmem_we   = rst_n & exmem_we_c;
    assign memwb_we   = rst_n & memwb_we_c;
    assign halted     = (state_q == S_HALTED);
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each driven cycle pushes its expected
// controls; a negedge monitor pops and compares once outputs have settled.
module tb_pipeline_ctrl;

    logic       clk, rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_halt, ex_memread, ex_branch_taken, mem_req, mem_ready;

    logic        pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we, halted;
    logic [15:0] stall_cnt;
    logic        pc_we4, ifid_we4, ifid_flush4, idex_flush4, exmem_we4, memwb_we4, halted4;
    logic [3:0]  stall_cnt4;

    pipeline_ctrl #(.CNT_W(16), .DRAIN_CYCLES(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_halt(id_halt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_we(exmem_we),
        .memwb_we(memwb_we), .halted(halted), .stall_cnt(stall_cnt)
    );

    pipeline_ctrl #(.CNT_W(4), .DRAIN_CYCLES(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_halt(id_halt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(pc_we4), .ifid_we(ifid_we4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .exmem_we(exmem_we4),
        .memwb_we(memwb_we4), .halted(halted4), .stall_cnt(stall_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // en = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we}
    typedef struct {
        int         n;
        logic [5:0] en;
        logic [5:0] mask;
        logic       hlt;
        int         st;
        int         st4;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_n = 0;

    localparam logic [5:0] E_IDLE = 6'b110011;
    localparam logic [5:0] E_LU   = 6'b000111;
    localparam logic [5:0] E_BR   = 6'b111111;
    localparam logic [5:0] E_FRZ  = 6'b000000;
    localparam logic [5:0] E_HALT = 6'b011011;
    localparam logic [5:0] E_DRN  = 6'b011111;
    localparam logic [5:0] M_ALL  = 6'b111111;
    localparam logic [5:0] M_WE   = 6'b110011;

    task automatic chk(input string tag, input int n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ctrl", e.n, {26'd0, {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we} & e.mask},
                {26'd0, e.en & e.mask});
            chk("halted", e.n, {31'd0, halted}, {31'd0, e.hlt});
            chk("stall_cnt", e.n, {16'd0, stall_cnt}, e.st);
            if (e.st4 >= 0) chk("stall_cnt4", e.n, {28'd0, stall_cnt4}, e.st4);
        end
    end

    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic halt, input logic mrd, input logic [4:0] ert,
                        input logic br, input logic mreq, input logic mrdy,
                        input logic [5:0] en, input logic [5:0] mask,
                        input logic hlt, input int st, input int st4);
        exp_t e;
        @(negedge clk);
        rst_n = rst; id_rs = rs; id_rt = rt; id_halt = halt; ex_memread = mrd;
        ex_rt = ert; ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
        step_n++;
        e.n = step_n; e.en = en; e.mask = mask; e.hlt = hlt; e.st = st; e.st4 = st4;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input logic [5:0] en, input logic hlt, input int st);
        step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, en, M_ALL, hlt, st, -1);
    endtask

    initial begin
        rst_n = 1'b0; id_rs = '0; id_rt = '0; id_halt = 0; ex_memread = 0;
        ex_rt = '0; ex_branch_taken = 0; mem_req = 0; mem_ready = 1;

        // reset state
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, E_FRZ, M_ALL, 0, 0, 0);
        idle(E_IDLE, 0, 0);

        // load-use via rs, then ex_rt=0 (no stall), then via rt
        step(1, 5'd8, 5'd3, 0, 1, 5'd8, 0, 0, 1, E_LU, M_ALL, 0, 0, -1);
        idle(E_IDLE, 0, 1);
        step(1, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 1, E_IDLE, M_ALL, 0, 1, -1);
        step(1, 5'd4, 5'd9, 0, 1, 5'd9, 0, 0, 1, E_LU, M_ALL, 0, 1, -1);
        idle(E_IDLE, 0, 2);

        // branch beats load-use and halt
        step(1, 5'd8, 5'd3, 1, 1, 5'd8, 1, 0, 1, E_BR, M_ALL, 0, 2, -1);
        idle(E_IDLE, 0, 2);

        // memory wait, 4 frozen cycles then ready
        for (int i = 0; i < 4; i++)
            step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, E_FRZ, M_ALL, 0, 2 + i, -1);
        step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 1, E_IDLE, M_ALL, 0, 6, -1);
        idle(E_IDLE, 0, 6);

        // ready cycle out of MEM_WAIT still resolves load-use
        step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, E_FRZ, M_ALL, 0, 6, -1);
        step(1, 5'd8, 5'd2, 0, 1, 5'd8, 0, 1, 1, E_LU, M_ALL, 0, 7, -1);
        idle(E_IDLE, 0, 8);

        // halt, 3 drain cycles, then halted forever
        step(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, E_HALT, M_ALL, 0, 8, -1);
        for (int i = 0; i < 3; i++) idle(E_DRN, 0, 9);
        idle(E_FRZ, 1, 9);
        step(1, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 1, E_FRZ, M_ALL, 1, 9, -1);
        idle(E_FRZ, 1, 9);

        // reset from HALTED
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, E_FRZ, M_ALL, 0, 0, -1);
        idle(E_IDLE, 0, 0);

        // halt with a 2-cycle memory freeze inside the drain
        step(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, E_HALT, M_ALL, 0, 0, -1);
        idle(E_DRN, 0, 1);
        for (int i = 0; i < 2; i++)
            step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, E_FRZ, M_WE, 0, 1, -1);
        idle(E_DRN, 0, 1);
        idle(E_DRN, 0, 1);
        idle(E_FRZ, 1, 1);

        // reset in MEM_WAIT abandons the wait
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, E_FRZ, M_ALL, 0, 0, 0);
        idle(E_IDLE, 0, 0);
        step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, E_FRZ, M_ALL, 0, 0, -1);
        step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, E_FRZ, M_ALL, 0, 1, -1);
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, E_FRZ, M_ALL, 0, 0, 0);
        idle(E_IDLE, 0, 0);

        // saturation of the 4-bit counter across 20 stall cycles
        for (int i = 0; i < 20; i++)
            step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, E_FRZ, M_ALL, 0, i, (i < 15) ? i : 15);
        step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, E_IDLE, M_ALL, 0, 20, 15);
        step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, E_IDLE, M_ALL, 0, 20, 15);

        @(negedge clk);
        #3;
        if (q.size() != 0) chk("queue_drained", 0, q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
